// File: rtl/pe_array_sequencer.sv
// Pass sequencer for the corelet MAC array: issues L0/IFIFO reads, MAC
// instructions, OS flushes and OFIFO writes, stalling on FIFO backpressure.
module pe_array_sequencer #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int inst_bw  = 3,
  parameter int KSIZE_BW = 5,
  parameter int CNT_BW   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                mode,
  input  logic [KSIZE_BW-1:0] kernel_size,
  input  logic [CNT_BW-1:0]   num_items,
  input  logic                l0_ready,
  input  logic                ififo_ready,
  input  logic                ofifo_full,
  output logic                l0_rd,
  output logic                ififo_rd,
  output logic [inst_bw-1:0]  inst_w,
  output logic                flush,
  output logic [col-1:0]      ofifo_wr,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int LD_BW = (row > 1) ? $clog2(row) : 1;
  localparam int DR_BW = $clog2(row + col);

  localparam logic [LD_BW-1:0] LD_LAST = LD_BW'(row - 1);
  localparam logic [DR_BW-1:0] DR_LAST = DR_BW'(row + col - 2);

  localparam logic [inst_bw-1:0] I_NOP  = '0;
  localparam logic [inst_bw-1:0] I_LOAD = inst_bw'(1);
  localparam logic [inst_bw-1:0] I_WEX  = inst_bw'(2);
  localparam logic [inst_bw-1:0] I_OSH  = inst_bw'(4);
  localparam logic [inst_bw-1:0] I_OEX  = inst_bw'(6);

  typedef enum logic [2:0] {
    IDLE, LOAD, EXEC, DRAIN, FLUSH, DONE
  } state_t;

  state_t              state;
  logic                cfg_mode;
  logic [KSIZE_BW-1:0] cfg_ksize;
  logic [CNT_BW-1:0]   cfg_items;
  logic [KSIZE_BW-1:0] k_cnt;
  logic [CNT_BW-1:0]   item_cnt;
  logic [LD_BW-1:0]    ld_cnt;
  logic [DR_BW-1:0]    dr_cnt;

  logic kill, adv_ws, adv_os, legal;
  logic [KSIZE_BW-1:0] k_last;
  logic [CNT_BW-1:0]   item_last;

  assign kill      = abort && (state != IDLE);
  assign adv_ws    = l0_ready && !ofifo_full;
  assign adv_os    = l0_ready && ififo_ready && !ofifo_full;
  assign legal     = !(mode && kernel_size == '0) && (num_items != '0);
  assign k_last    = cfg_ksize - 1'b1;
  assign item_last = cfg_items - 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cfg_mode  <= 1'b0;
      cfg_ksize <= '0;
      cfg_items <= '0;
      k_cnt     <= '0;
      item_cnt  <= '0;
      ld_cnt    <= '0;
      dr_cnt    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (kill) begin
        state    <= IDLE;
        k_cnt    <= '0;
        item_cnt <= '0;
        ld_cnt   <= '0;
        dr_cnt   <= '0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            cfg_mode  <= mode;
            cfg_ksize <= kernel_size;
            cfg_items <= num_items;
            k_cnt     <= '0;
            item_cnt  <= '0;
            ld_cnt    <= '0;
            dr_cnt    <= '0;
            busy      <= 1'b1;
            if (!legal) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= mode ? EXEC : LOAD;
            end
          end
          LOAD: if (l0_ready) begin
            if (ld_cnt == LD_LAST) begin
              ld_cnt <= '0;
              state  <= EXEC;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end
          EXEC: if (cfg_mode) begin
            if (adv_os) begin
              if (k_cnt == k_last) begin
                k_cnt <= '0;
                state <= FLUSH;
              end else begin
                k_cnt <= k_cnt + 1'b1;
              end
            end
          end else if (adv_ws) begin
            if (item_cnt == item_last) begin
              item_cnt <= '0;
              dr_cnt   <= '0;
              state    <= DRAIN;
            end else begin
              item_cnt <= item_cnt + 1'b1;
            end
          end
          FLUSH: if (!ofifo_full) begin
            if (item_cnt == item_last) begin
              item_cnt <= '0;
              state    <= DONE;
              done     <= 1'b1;
            end else begin
              item_cnt <= item_cnt + 1'b1;
              state    <= EXEC;
            end
          end
          DRAIN: if (dr_cnt == DR_LAST) begin
            dr_cnt <= '0;
            state  <= DONE;
            done   <= 1'b1;
          end else begin
            dr_cnt <= dr_cnt + 1'b1;
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Strobes follow the ready inputs in the same cycle so a stall costs no bubble.
  always_comb begin
    l0_rd    = 1'b0;
    ififo_rd = 1'b0;
    inst_w   = I_NOP;
    flush    = 1'b0;
    ofifo_wr = '0;
    if (!kill) begin
      case (state)
        LOAD: if (l0_ready) begin
          inst_w = I_LOAD;
          l0_rd  = 1'b1;
        end
        EXEC: if (cfg_mode) begin
          inst_w   = adv_os ? I_OEX : I_OSH;
          l0_rd    = adv_os;
          ififo_rd = adv_os;
        end else if (adv_ws) begin
          inst_w = I_WEX;
          l0_rd  = 1'b1;
        end
        FLUSH: begin
          inst_w = I_OSH;
          if (!ofifo_full) begin
            flush    = 1'b1;
            ofifo_wr = '1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
